temp_window_stats: RTL and testbench

TEMP_WINDOW_STATS -- requirements
Module: temp_window_stats

---
 rtl/temp_window_stats.sv | 121 ++++++++++++
 tb/tb_temp_window_stats.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/temp_window_stats.sv
// Sliding-window temperature statistics: running sum over a DEPTH-deep circular
// buffer, min/max since clear, and an iterative restoring divider for the average.
module temp_window_stats #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         avg_temp,
  output logic [WIDTH-1:0]         min_temp,
  output logic [WIDTH-1:0]         max_temp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     stats_valid
);
  localparam int PW   = $clog2(DEPTH);
  localparam int SUMW = WIDTH + PW;
  localparam int CW   = PW + 1;
  localparam int IW   = $clog2(SUMW + 1);

  typedef enum logic {IDLE, DIV} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]   wr_ptr;
  logic [SUMW-1:0] sum, sum_nxt;
  logic [SUMW-1:0] rem, rem_nxt;
  logic [SUMW-1:0] quo, quo_nxt;
  logic [SUMW:0]   shifted, diff;
  logic [IW-1:0]   iter;
  logic            q_bit, accept, last_iter;

  assign accept    = in_valid & in_ready;
  assign last_iter = (state == DIV) && (iter == IW'(SUMW - 1));
  assign full      = (count == CW'(DEPTH));

  // Oldest sample leaves the window only once it is full; buffer read is pre-write.
  assign sum_nxt = sum + SUMW'(in_data) - (full ? SUMW'(mem[wr_ptr]) : SUMW'(0));

  // One restoring step: shift in the next dividend bit, trial-subtract the count.
  assign shifted = {rem, quo[SUMW-1]};
  assign diff    = shifted - (SUMW+1)'(count);
  assign q_bit   = ~diff[SUMW];
  assign rem_nxt = q_bit ? diff[SUMW-1:0] : shifted[SUMW-1:0];
  assign quo_nxt = {quo[SUMW-2:0], q_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (!clr && in_valid) state_nxt = DIV;
      end
      DIV: begin
        if (clr || last_iter) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer contents are never reset; sum and count gate their use.
  always_ff @(posedge clk) begin
    if (accept && !clr) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      sum         <= '0;
      count       <= '0;
      min_temp    <= '1;
      max_temp    <= '0;
      avg_temp    <= '0;
      stats_valid <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      iter        <= '0;
    end else if (clr) begin
      wr_ptr      <= '0;
      sum         <= '0;
      count       <= '0;
      min_temp    <= '1;
      max_temp    <= '0;
      avg_temp    <= '0;
      stats_valid <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      iter        <= '0;
    end else begin
      stats_valid <= 1'b0;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        sum    <= sum_nxt;
        quo    <= sum_nxt;
        rem    <= '0;
        iter   <= '0;
        if (!full) count <= count + 1'b1;
        if (in_data < min_temp) min_temp <= in_data;
        if (in_data > max_temp) max_temp <= in_data;
      end else if (state == DIV) begin
        rem  <= rem_nxt;
        quo  <= quo_nxt;
        iter <= iter + 1'b1;
        if (last_iter) begin
          avg_temp    <= quo_nxt[WIDTH-1:0];
          stats_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_temp_window_stats.sv
// Directed bench for temp_window_stats at WIDTH=8, DEPTH=4 (divider latency 11).
module tb_temp_window_stats;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, full, stats_valid;
  logic [7:0] avg_temp, min_temp, max_temp;
  logic [2:0] count;

  int vectors = 0;
  int miscompares = 0;

  temp_window_stats #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .avg_temp(avg_temp), .min_temp(min_temp), .max_temp(max_temp),
    .count(count), .full(full), .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for a single cycle; returns in cycle T+1.
  task automatic accept(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Called in cycle T+1; returns in the stats_valid cycle, checking latency and ready.
  task automatic wait_done(input string tag);
    int  n = 1;
    bit  rdy_bad = 0;
    while (!stats_valid && n < 40) begin
      if (in_ready) rdy_bad = 1;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 11);
    chk({tag, "_rdy_lo"}, int'(rdy_bad), 0);
    chk({tag, "_rdy_hi"}, int'(in_ready), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, int'(in_ready), 1);
    chk({tag, "_avg"}, int'(avg_temp), 0);
    chk({tag, "_min"}, int'(min_temp), 255);
    chk({tag, "_max"}, int'(max_temp), 0);
    chk({tag, "_cnt"}, int'(count), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_sv"}, int'(stats_valid), 0);
  endtask

  task automatic no_pulse(input string tag, input int cycles);
    bit seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (stats_valid) seen = 1;
      tick();
    end
    chk({tag, "_nopulse"}, int'(seen), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    // Scenario 1: reset, single accept
    do_reset();
    check_reset_vals("rst");
    accept(8'd70);
    chk("s1_min", int'(min_temp), 70);
    chk("s1_max", int'(max_temp), 70);
    chk("s1_cnt", int'(count), 1);
    chk("s1_avg_hold", int'(avg_temp), 0);
    wait_done("s1");
    chk("s1_avg", int'(avg_temp), 70);
    tick();
    chk("s1_sv_drop", int'(stats_valid), 0);

    // Scenario 2: 70, 71, 73 -> 214/3 = 71
    accept(8'd71);
    wait_done("s2a");
    chk("s2_avg2", int'(avg_temp), 70);
    accept(8'd73);
    wait_done("s2b");
    chk("s2_avg", int'(avg_temp), 71);
    chk("s2_min", int'(min_temp), 70);
    chk("s2_max", int'(max_temp), 73);
    chk("s2_cnt", int'(count), 3);

    // Scenario 3: window wrap
    do_reset();
    accept(8'd60); wait_done("s3a");
    accept(8'd64); wait_done("s3b");
    accept(8'd68); wait_done("s3c");
    accept(8'd72); wait_done("s3d");
    chk("s3_avg4", int'(avg_temp), 66);
    chk("s3_full4", int'(full), 1);
    accept(8'd76); wait_done("s3e");
    chk("s3_avg", int'(avg_temp), 70);
    chk("s3_min", int'(min_temp), 60);
    chk("s3_max", int'(max_temp), 76);
    chk("s3_cnt", int'(count), 4);
    chk("s3_full", int'(full), 1);

    // Scenario 4: in_valid held with 99 through DIV
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'd80;
    tick();
    in_data  = 8'd99;
    begin
      int n = 1;
      bit cnt_bad = 0;
      while (!stats_valid && n < 40) begin
        if (count != 3'd1) cnt_bad = 1;
        tick();
        n++;
      end
      chk("s4_lat", n, 11);
      chk("s4_cnt_hold", int'(cnt_bad), 0);
    end
    chk("s4_cnt1", int'(count), 1);
    chk("s4_avg1", int'(avg_temp), 80);
    tick();
    in_valid = 1'b0;
    chk("s4_cnt2", int'(count), 2);
    chk("s4_max", int'(max_temp), 99);
    chk("s4_min", int'(min_temp), 80);
    wait_done("s4b");
    chk("s4_avg", int'(avg_temp), 89);

    // Scenario 5: clr at T+5 aborts the division
    accept(8'd50);
    tick(); tick(); tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_reset_vals("s5");
    no_pulse("s5", 15);
    // clr wins over a simultaneous accept
    in_valid = 1'b1;
    in_data  = 8'd40;
    clr      = 1'b1;
    tick();
    in_valid = 1'b0;
    clr      = 1'b0;
    check_reset_vals("s5clr_acc");

    // Scenario 6: saturated samples, then rst mid-DIV
    do_reset();
    for (int i = 0; i < 4; i++) begin
      accept(8'd255);
      wait_done("s6");
      chk("s6_avg", int'(avg_temp), 255);
    end
    chk("s6_full", int'(full), 1);
    accept(8'd255);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check_reset_vals("s6_rst");
    tick();
    rst = 1'b1;
    no_pulse("s6", 15);
    check_reset_vals("s6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
